// File: rtl/serial_tx_if.sv
// Word-source to serial transmitter link: parallel word handshake in, serial bit/command stream out.
// master = word source, slave = transmitter.
interface serial_tx_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] data_in;
  logic             dir;
  logic             valid;
  logic             ready;
  logic             serial_out;
  logic [1:0]       op_out;
  logic             busy;
  logic             done;

  modport master (
    output data_in, dir, valid,
    input  ready, serial_out, op_out, busy, done
  );

  modport slave (
    input  data_in, dir, valid,
    output ready, serial_out, op_out, busy, done
  );
endinterface

// File: rtl/serial_tx.sv
// Parallel-to-serial transmitter driving a shift-register receiver (bit + shift command per cycle).
// Latency: first bit one clock after accept; WIDTH shift cycles, then a one-cycle done pulse.
// Backpressure: ready only in IDLE; valid while busy is dropped, the source must hold it.
module serial_tx #(
  parameter int WIDTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  serial_tx_if.slave  bus
);
  localparam int            CW       = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST     = CW'(WIDTH - 1);
  localparam logic [1:0]    OP_HOLD  = 2'b00;
  localparam logic [1:0]    OP_LEFT  = 2'b01;
  localparam logic [1:0]    OP_RIGHT = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ser_q, ser_d;
  logic [1:0]       op_q, op_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ser_q   <= 1'b0;
      op_q    <= OP_HOLD;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ser_q   <= ser_d;
      op_q    <= op_d;
    end
  end

  // Outputs are computed for the next cycle so every port comes straight from a flop.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    ready_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    ser_d   = 1'b0;
    op_d    = OP_HOLD;
    case (state_q)
      IDLE: begin
        if (bus.valid && ready_q) begin
          state_d = SHIFT;
          shreg_d = bus.data_in;
          dir_d   = bus.dir;
          cnt_d   = '0;
          busy_d  = 1'b1;
          op_d    = bus.dir ? OP_RIGHT : OP_LEFT;
          ser_d   = bus.dir ? bus.data_in[0] : bus.data_in[WIDTH-1];
        end else begin
          ready_d = 1'b1;
        end
      end
      SHIFT: begin
        if (cnt_q == LAST) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          // The bit to present next sits one position inward from the outgoing end.
          cnt_d   = cnt_q + CW'(1);
          shreg_d = dir_q ? (shreg_q >> 1) : (shreg_q << 1);
          busy_d  = 1'b1;
          op_d    = dir_q ? OP_RIGHT : OP_LEFT;
          ser_d   = dir_q ? shreg_q[1] : shreg_q[WIDTH-2];
        end
      end
      DONE: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  assign bus.ready      = ready_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.serial_out = ser_q;
  assign bus.op_out     = op_q;
endmodule

// File: tb/tb_serial_tx.sv
// Randomised bench for serial_tx: per-cycle comparison against a word/phase reference model
// plus an attached shift-register receiver that must end up holding each word.
module tb_serial_tx;
  localparam int W = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  serial_tx_if #(.WIDTH(W)) bus ();

  serial_tx #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: phase 0 = idle, 1..W = shifting bit (phase-1), W+1 = done pulse.
  int          phase = 0;
  logic [W-1:0] m_word = '0;
  logic        m_dir = 1'b0;
  int          m_accepts = 0;
  int          dut_dones = 0;
  int          cyc = 0;
  int          prev_acc = -1;
  bit          spacing_on = 1'b0;

  // Receiver attached to the transmitter, exactly as a downstream shift register would be.
  logic [W-1:0] rx;
  always @(posedge clk) begin
    if (bus.op_out == 2'b01)      rx <= {rx[W-2:0], bus.serial_out};
    else if (bus.op_out == 2'b10) rx <= {bus.serial_out, rx[W-1:1]};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // {ready, busy, done, op_out[1:0], serial_out}
  function automatic logic [5:0] expect_out();
    int k;
    logic b;
    if (phase == 0)      return 6'b100000;
    if (phase == W + 1)  return 6'b001000;
    k = phase - 1;
    b = m_dir ? m_word[k] : m_word[W-1-k];
    return {3'b010, (m_dir ? 2'b10 : 2'b01), b};
  endfunction

  task automatic cycle(input logic r, input logic v, input logic [W-1:0] d, input logic dr);
    reset        = r;
    bus.valid    = v;
    bus.data_in  = d;
    bus.dir      = dr;
    if (spacing_on && !r && v && bus.ready) begin
      if (prev_acc >= 0) check("spacing", cyc - prev_acc, W + 2);
      prev_acc = cyc;
    end
    @(posedge clk);
    if (r) phase = 0;
    else if (phase == 0) begin
      if (v) begin
        m_word = d;
        m_dir  = dr;
        phase  = 1;
        m_accepts++;
      end
    end else if (phase <= W) phase++;
    else phase = 0;
    cyc++;
    @(negedge clk);
    check("out", {bus.ready, bus.busy, bus.done, bus.op_out, bus.serial_out}, expect_out());
    if (phase == W + 1) check("rx", rx, m_word);
    if (bus.done) dut_dones++;
  endtask

  // Drive garbage on the data lines while the word is in flight; optionally inject resets.
  task automatic drain(input bit allow_rst);
    int n = 0;
    while (phase != 0 && n < 4 * W) begin
      cycle(allow_rst && ($urandom_range(0, 15) == 0), $urandom_range(0, 1),
            W'($urandom), $urandom_range(0, 1));
      n++;
    end
  endtask

  task automatic send(input logic [W-1:0] d, input logic dr, input bit allow_rst);
    int a0 = m_accepts;
    int n = 0;
    while (m_accepts == a0 && n < 4 * W) begin
      cycle(1'b0, 1'b1, d, dr);
      n++;
    end
    drain(allow_rst);
  endtask

  initial begin
    int d0;
    bus.valid   = 1'b0;
    bus.data_in = '0;
    bus.dir     = 1'b0;

    // Reset held two cycles with valid high: nothing accepted until reset drops.
    cycle(1'b1, 1'b1, 4'b1010, 1'b0);
    cycle(1'b1, 1'b1, 4'b1010, 1'b0);
    cycle(1'b0, 1'b1, 4'b1010, 1'b0);
    check("acc_after_rst", bus.busy, 1'b1);
    drain(1'b0);

    // Directed words in both bit orders.
    d0 = dut_dones;
    send(4'b1011, 1'b0, 1'b0);
    send(4'b1011, 1'b1, 1'b0);
    check("done_cnt2", dut_dones - d0, 2);
    cycle(1'b0, 1'b0, '0, 1'b0);

    // New data and a valid pulse during SHIFT must not disturb the word in flight.
    d0 = dut_dones;
    cycle(1'b0, 1'b1, 4'b0110, 1'b0);
    cycle(1'b0, 1'b1, 4'b1111, 1'b1);
    cycle(1'b0, 1'b0, 4'b1111, 1'b1);
    drain(1'b0);
    check("done_once", dut_dones - d0, 1);

    // Reset in the third SHIFT cycle discards the word without a done pulse.
    d0 = dut_dones;
    cycle(1'b0, 1'b1, 4'b1110, 1'b0);
    cycle(1'b0, 1'b0, 4'b0000, 1'b0);
    cycle(1'b0, 1'b0, 4'b0000, 1'b0);
    cycle(1'b1, 1'b0, 4'b0000, 1'b0);
    cycle(1'b0, 1'b0, 4'b0000, 1'b0);
    check("no_done_rst", dut_dones - d0, 0);
    send(4'b1001, 1'b0, 1'b0);

    // All-zero and all-one words still shift for the full width.
    send(4'b0000, 1'b0, 1'b0);
    send(4'b1111, 1'b1, 1'b0);

    // Valid held continuously with alternating words: one accept every W+2 cycles.
    d0 = m_accepts;
    prev_acc = -1;
    spacing_on = 1'b1;
    for (int i = 0; i < 5 * (W + 2); i++)
      cycle(1'b0, 1'b1, ((m_accepts - d0) % 2) ? 4'b0011 : 4'b1100, 1'b0);
    spacing_on = 1'b0;
    drain(1'b0);

    // Randomised traffic with idle gaps, garbage inputs in flight and occasional resets.
    for (int i = 0; i < 60; i++) begin
      int gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) cycle(1'b0, 1'b0, W'($urandom), $urandom_range(0, 1));
      send(W'($urandom), $urandom_range(0, 1), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
